// File: rtl/k16_io_expander_if.sv
// k16_io_expander_if
//   Nibble-serial K16 I/O bus between the CPU-side multiplexer (master)
//   and the board-side expander (slave).
//   select     : slot index 0..7, advanced by the CPU side every clk
//   outputBits : outbound nibble, carries nibble (select-1) mod 8
//   inputBits  : inbound nibble, must hold nibble select
interface k16_io_expander_if;
    logic [2:0] select;
    logic [3:0] outputBits;
    logic [3:0] inputBits;

    modport master (output select, output outputBits, input inputBits);
    modport slave  (input select, input outputBits, output inputBits);
endinterface

// File: rtl/k16_io_expander.sv
// k16_io_expander
//   Board-side responder for the K16 nibble-serial I/O bus. Collects the
//   eight outbound nibbles of a frame into a shadow register and commits
//   them atomically to two 16-bit output words; serves two 16-bit input
//   words back as nibbles from a snapshot taken once per frame.
//
// Ports:
//   clk, reset         : clock shared with the CPU side; sync active-high reset
//   bus (slave)        : select / outputBits in, inputBits out
//   extOutput0/1       : committed output words (nibbles 0..3 / 4..7)
//   extInput0/1        : external input words (asynchronous to clk)
//   frameStrobe        : one-cycle pulse while freshly committed outputs show
//   locked             : high after a clean committed frame, cleared on error
//   errorCount         : saturating count of select sequence errors
//
// Build option:
//   K16IO_INPUT_SYNC_EN : when defined, extInput0/1 pass through a 2-flop
//                         synchronizer before the snapshot.
module k16_io_expander #(
    parameter logic [15:0] RESET_OUT0 = 16'h0000,
    parameter logic [15:0] RESET_OUT1 = 16'h0000
) (
    input  logic                    clk,
    input  logic                    reset,
    k16_io_expander_if.slave        bus,
    output logic [15:0]             extOutput0,
    output logic [15:0]             extOutput1,
    input  logic [15:0]             extInput0,
    input  logic [15:0]             extInput1,
    output logic                    frameStrobe,
    output logic                    locked,
    output logic [7:0]              errorCount
);
    logic [2:0]  last_sel;
    logic        clean;
    logic [31:0] shadow;
    logic [31:0] snapshot;
    logic [31:0] in_word;
    logic [2:0]  exp_sel;
    logic [2:0]  cap_idx;
    logic        mismatch;
    logic        commit;

    assign exp_sel  = last_sel + 3'd1;
    assign mismatch = (bus.select != exp_sel);
    // outputBits lags select by one slot
    assign cap_idx  = bus.select - 3'd1;
    // Commit needs an unbroken 1..7 run followed by this in-order 0
    assign commit   = (bus.select == 3'd0) && !mismatch && clean;

    // CPU samples this at the edge where select==k, so it is purely
    // combinational from select and the registered snapshot.
    assign bus.inputBits = snapshot[{bus.select, 2'b00} +: 4];

`ifdef K16IO_INPUT_SYNC_EN
    logic [31:0] sync_q1;
    logic [31:0] sync_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {extInput1, extInput0};
            sync_q2 <= sync_q1;
        end
    end

    assign in_word = sync_q2;
`else
    assign in_word = {extInput1, extInput0};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            extOutput0  <= RESET_OUT0;
            extOutput1  <= RESET_OUT1;
            snapshot    <= '0;
            frameStrobe <= 1'b0;
            locked      <= 1'b0;
            errorCount  <= 8'd0;
            last_sel    <= 3'd7;
            clean       <= 1'b0;
            shadow      <= '0;
        end else begin
            last_sel    <= bus.select;
            shadow[{cap_idx, 2'b00} +: 4] <= bus.outputBits;
            frameStrobe <= commit;

            // Reload at the last slot so the next 0..7 frame reads one sample
            if (bus.select == 3'd7)
                snapshot <= in_word;

            if (mismatch) begin
                clean  <= 1'b0;
                locked <= 1'b0;
                if (errorCount != 8'hFF)
                    errorCount <= errorCount + 8'd1;
            end else if (bus.select == 3'd1) begin
                clean <= 1'b1;
            end

            if (commit) begin
                extOutput0 <= shadow[15:0];
                // Nibble 7 arrives on the commit edge itself
                extOutput1 <= {bus.outputBits, shadow[27:16]};
                locked     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_k16_io_expander.sv
// tb_k16_io_expander
//   CPU-side model driving the select sequence and outbound nibbles,
//   reassembling inbound words; expected output commits and input words
//   are queued when stimulus is driven and compared when the DUT delivers.
module tb_k16_io_expander;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] extOutput0, extOutput1;
    logic [15:0] extInput0, extInput1;
    logic        frameStrobe, locked;
    logic [7:0]  errorCount;

    k16_io_expander_if bus ();

    k16_io_expander #(
        .RESET_OUT0 (16'hA5A5),
        .RESET_OUT1 (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .extOutput0  (extOutput0),
        .extOutput1  (extOutput1),
        .extInput0   (extInput0),
        .extInput1   (extInput1),
        .frameStrobe (frameStrobe),
        .locked      (locked),
        .errorCount  (errorCount)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] cpu_out;
    logic [31:0] cpu_in;
    logic [31:0] out_q[$];
    logic [31:0] in_q[$];
    logic        in_ok;
    logic [2:0]  in_next;
    logic        chg_en;
    logic [2:0]  chg_at;
    logic [15:0] chg_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus slot: drive at negedge, sample inputBits before the edge,
    // sample registered outputs 1ns after it.
    task automatic step(input logic [2:0] s);
        logic [2:0]  n;
        logic [31:0] e;
        @(negedge clk);
        reset = 1'b0;
        n = s - 3'd1;
        bus.select = s;
        bus.outputBits = cpu_out[{n, 2'b00} +: 4];
        if (chg_en && chg_at == s) begin
            extInput0 = chg_val;
            chg_en = 1'b0;
        end
        #1;
        if (s == 3'd0) begin
            in_ok = 1'b1;
            in_next = 3'd1;
            cpu_in[3:0] = bus.inputBits;
        end else if (in_ok && s == in_next) begin
            cpu_in[{s, 2'b00} +: 4] = bus.inputBits;
            in_next = s + 3'd1;
        end else begin
            in_ok = 1'b0;
        end
        if (s == 3'd7) begin
            e = in_q.pop_front();
            if (in_ok) chk("in_word", cpu_in, e);
            in_ok = 1'b0;
            in_q.push_back({extInput1, extInput0});
        end
        @(posedge clk);
        #1;
        if (frameStrobe) begin
            if (out_q.size() == 0) begin
                chk("unexp_strobe", {31'd0, frameStrobe}, 32'd0);
            end else begin
                e = out_q.pop_front();
                chk("ext_out", {extOutput1, extOutput0}, e);
            end
        end
    endtask

    // Slots first_k..7 then 0; optionally expects a commit at the 0.
    task automatic frame(input int first_k, input bit commit_exp);
        if (commit_exp) out_q.push_back(cpu_out);
        for (int k = first_k; k < 8; k++) step(3'(k));
        step(3'd0);
        if (commit_exp) chk("strobe_seen", out_q.size(), 32'd0);
    endtask

    task automatic do_reset(input logic [2:0] s);
        @(negedge clk);
        reset = 1'b1;
        bus.select = s;
        bus.outputBits = 4'h0;
        @(posedge clk);
        #1;
        in_q.delete();
        in_q.push_back(32'd0);
        in_ok = 1'b0;
    endtask

    initial begin
        cpu_out = {16'hBEEF, 16'h1234};
        cpu_in = '0;
        extInput0 = 16'hCAFE;
        extInput1 = 16'h0F0F;
        bus.select = 3'd0;
        bus.outputBits = 4'h0;
        in_ok = 1'b0;
        in_next = 3'd0;
        chg_en = 1'b0;
        chg_at = 3'd0;
        chg_val = 16'h0;
        in_q.push_back(32'd0);

        // Reset state
        do_reset(3'd0);
        chk("rst_out0", extOutput0, 32'hA5A5);
        chk("rst_out1", extOutput1, 32'h0);
        chk("rst_locked", locked, 32'd0);
        chk("rst_err", errorCount, 32'd0);
        chk("rst_strobe", frameStrobe, 32'd0);
        for (int s = 0; s < 8; s++) begin
            bus.select = 3'(s);
            #1;
            chk("rst_in", bus.inputBits, 32'd0);
        end

        // First commit after a full in-order 1..7,0 run
        step(3'd0);
        chk("err_start", errorCount, 32'd0);
        chk("locked_pre", locked, 32'd0);
        frame(1, 1'b1);
        chk("ext0_first", extOutput0, 32'h1234);
        chk("ext1_first", extOutput1, 32'hBEEF);
        chk("locked_first", locked, 32'd1);
        step(3'd1);
        chk("strobe_pulse", frameStrobe, 32'd0);
        frame(2, 1'b1);

        // Input snapshot coherence: 0000 -> FFFF switched mid-frame
        extInput0 = 16'h0000;
        frame(1, 1'b1);
        chg_en = 1'b1;
        chg_at = 3'd3;
        chg_val = 16'hFFFF;
        frame(1, 1'b1);
        frame(1, 1'b1);

        // Broken sequence 0,1,2,5,6,7,0: no commit, then recovery
        cpu_out = {16'h7E57, 16'h0C0D};
        step(3'd1); step(3'd2); step(3'd5); step(3'd6); step(3'd7); step(3'd0);
        chk("err_one", errorCount, 32'd1);
        chk("locked_err", locked, 32'd0);
        chk("ext_hold", {extOutput1, extOutput0}, {16'hBEEF, 16'h1234});
        frame(1, 1'b1);
        chk("locked_again", locked, 32'd1);
        chk("err_still_one", errorCount, 32'd1);

        // Stuck select: error count saturates, outputs hold
        cpu_out = {16'hDEAD, 16'h5A5A};
        for (int i = 0; i < 300; i++) step(3'd3);
        chk("err_sat", errorCount, 32'd255);
        chk("ext_stuck", {extOutput1, extOutput0}, {16'h7E57, 16'h0C0D});
        chk("locked_stuck", locked, 32'd0);
        step(3'd0);
        chk("err_sat_hold", errorCount, 32'd255);
        frame(1, 1'b1);

        // Reset at select==4 discards the pending frame
        cpu_out = {16'h6666, 16'h5555};
        step(3'd1); step(3'd2); step(3'd3);
        do_reset(3'd4);
        chk("mrst_out", {extOutput1, extOutput0}, {16'h0000, 16'hA5A5});
        chk("mrst_err", errorCount, 32'd0);
        chk("mrst_locked", locked, 32'd0);
        step(3'd0);
        chk("mrst_nocommit", {extOutput1, extOutput0}, {16'h0000, 16'hA5A5});
        frame(1, 1'b1);
        chk("mrst_recover", locked, 32'd1);

        chk("outq_empty", out_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
